// File: rtl/pit_bus_master.sv
// pit_bus_master: turns one program/read command into the 8253 bus-cycle
// sequence (control word, then LSB/MSB transfers) with tunable setup/strobe/hold.
module pit_bus_master #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [1:0]  cmd_chan,
    input  logic [1:0]  cmd_rw,
    input  logic [2:0]  cmd_mode,
    input  logic        cmd_bcd,
    input  logic [15:0] cmd_count,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_data,
    output logic        cs_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        a1,
    output logic        a0,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in
);
    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, HOLD, GAP, DONE
    } state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        op_q, op_d;
    logic [1:0]  chan_q, chan_d;
    logic [1:0]  rw_q, rw_d;
    logic [2:0]  mode_q, mode_d;
    logic        bcd_q, bcd_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic        err_q, err_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;

    logic        illegal;
    logic        read_cyc;
    logic        has_next;
    logic [1:0]  next_idx;
    logic        busy_d;
    logic        wr_cyc_d;
    logic [7:0]  ctrl_d;
    logic [7:0]  wdata_d;

    // idx: 0 = control/latch word, 1 = LSB transfer, 2 = MSB transfer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        op_d     = op_q;
        chan_d   = chan_q;
        rw_d     = rw_q;
        mode_d   = mode_q;
        bcd_d    = bcd_q;
        count_d  = count_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        err_d    = err_q;

        illegal  = (cmd_chan == 2'd3) || (cmd_rw == 2'b00)
                   || (!cmd_op && (cmd_mode > 3'd5));
        read_cyc = op_q && (idx_q != 2'd0);

        has_next = 1'b0;
        next_idx = idx_q;
        if (idx_q == 2'd0) begin
            if (rw_q[0]) begin
                has_next = 1'b1;
                next_idx = 2'd1;
            end else if (rw_q[1]) begin
                has_next = 1'b1;
                next_idx = 2'd2;
            end
        end else if ((idx_q == 2'd1) && rw_q[1]) begin
            has_next = 1'b1;
            next_idx = 2'd2;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = cmd_op;
                    chan_d  = cmd_chan;
                    rw_d    = cmd_rw;
                    mode_d  = cmd_mode;
                    bcd_d   = cmd_bcd;
                    count_d = cmd_count;
                    lo_d    = 8'h00;
                    hi_d    = 8'h00;
                    err_d   = illegal;
                    idx_d   = 2'd0;
                    cnt_d   = SETUP_LD;
                    state_d = illegal ? DONE : SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    if (read_cyc) begin
                        if (idx_q == 2'd1) begin
                            lo_d = d_in;
                        end else begin
                            hi_d = d_in;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GAP: begin
                if (has_next) begin
                    state_d = SETUP;
                    idx_d   = next_idx;
                    cnt_d   = SETUP_LD;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // bus pins are registered from the state being entered
        busy_d   = (state_d == SETUP) || (state_d == STROBE)
                   || (state_d == HOLD);
        wr_cyc_d = !op_d || (idx_d == 2'd0);
        ctrl_d   = op_d ? {chan_d, 6'b000000}
                        : {chan_d, rw_d, mode_d, bcd_d};
        if (idx_d == 2'd0) begin
            wdata_d = ctrl_d;
        end else if (idx_d == 2'd1) begin
            wdata_d = count_d[7:0];
        end else begin
            wdata_d = count_d[15:8];
        end

        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
        rsp_err_d   = (state_d == DONE) && err_d;
        rsp_data_d  = (state_d == DONE) ? {hi_d, lo_d} : rsp_data_q;
        cs_n_d      = !busy_d;
        wr_n_d      = !((state_d == STROBE) && wr_cyc_d);
        rd_n_d      = !((state_d == STROBE) && !wr_cyc_d);
        d_oe_d      = busy_d && wr_cyc_d;
        addr_d      = addr_q;
        d_out_d     = d_out_q;
        if (busy_d) begin
            addr_d = (idx_d == 2'd0) ? 2'b11 : chan_d;
            if (wr_cyc_d) begin
                d_out_d = wdata_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= 2'd0;
            op_q        <= 1'b0;
            chan_q      <= 2'd0;
            rw_q        <= 2'd0;
            mode_q      <= 3'd0;
            bcd_q       <= 1'b0;
            count_q     <= 16'h0000;
            lo_q        <= 8'h00;
            hi_q        <= 8'h00;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 16'h0000;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            addr_q      <= 2'b00;
            d_out_q     <= 8'h00;
            d_oe_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            chan_q      <= chan_d;
            rw_q        <= rw_d;
            mode_q      <= mode_d;
            bcd_q       <= bcd_d;
            count_q     <= count_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            addr_q      <= addr_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign cs_n      = cs_n_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign a1        = addr_q[1];
    assign a0        = addr_q[0];
    assign d_out     = d_out_q;
    assign d_oe      = d_oe_q;

endmodule

// File: tb/tb_pit_bus_master.sv
// tb_pit_bus_master: vector table, reset/back-to-back sequences and random
// commands checked against a command-level model and a bus timing monitor.
module tb_pit_bus_master;
    localparam int S       = 2;
    localparam int ST      = 3;
    localparam int H       = 1;
    localparam int BUS_CYC = S + ST + H + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [1:0]  cmd_chan;
    logic [1:0]  cmd_rw;
    logic [2:0]  cmd_mode;
    logic        cmd_bcd;
    logic [15:0] cmd_count;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_data;
    logic        cs_n, rd_n, wr_n, a1, a0, d_oe;
    logic [7:0]  d_out;
    logic [7:0]  d_in;

    always #5 clk = ~clk;

    pit_bus_master #(
        .SETUP_CYC  (S),
        .STROBE_CYC (ST),
        .HOLD_CYC   (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_chan  (cmd_chan),
        .cmd_rw    (cmd_rw),
        .cmd_mode  (cmd_mode),
        .cmd_bcd   (cmd_bcd),
        .cmd_count (cmd_count),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .a1        (a1),
        .a0        (a0),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .d_in      (d_in)
    );

    typedef struct packed {
        logic       wr;
        logic [1:0] a;
        logic [7:0] data;
    } bus_op_t;

    typedef struct packed {
        logic        op;
        logic [1:0]  chan;
        logic [1:0]  rw;
        logic [2:0]  mode;
        logic        bcd;
        logic [15:0] count;
    } cmd_t;

    typedef struct {
        cmd_t        cmd;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [7:0]  exp_ctrl;
        int          exp_nwr;
        int          exp_nrd;
        logic        exp_err;
        logic [15:0] exp_data;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    bus_op_t     bus_log[$];
    bus_op_t     exp_q[$];
    logic [7:0]  rd_q[$];
    logic        exp_err;
    logic [15:0] exp_data;
    logic        last_err;
    logic [15:0] last_data;
    bit          mon_en = 0;
    vec_t        vq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Bus monitor: plays the 8253 read data and measures every bus cycle
    logic [7:0] su, st, ho, cd, rdv;
    logic [1:0] ca;
    logic       coe, cwr, stable, in_cyc = 0;

    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            in_cyc = 0;
        end else begin
            if (!cs_n) begin
                chk("strobe_excl", {31'd0, rd_n | wr_n}, 1);
                chk("oe_vs_rd", {31'd0, d_oe & ~rd_n}, 0);
                if (!in_cyc) begin
                    in_cyc = 1; su = 0; st = 0; ho = 0;
                    ca = {a1, a0}; cd = d_out; coe = d_oe;
                    cwr = 0; stable = 1; rdv = 0;
                end
                if ({a1, a0} != ca || d_oe != coe || (coe && d_out != cd))
                    stable = 0;
                if (!wr_n || !rd_n) begin
                    st++;
                    if (!wr_n) cwr = 1;
                    if (!rd_n) rdv = d_in;
                end else if (st == 0) begin
                    su++;
                end else begin
                    ho++;
                end
            end else if (in_cyc) begin
                in_cyc = 0;
                chk("cyc_timing", {8'd0, su, st, ho},
                    {8'd0, 8'(S), 8'(ST), 8'(H)});
                chk("cyc_stable", {31'd0, stable}, 1);
                chk("gap_oe", {31'd0, d_oe}, 0);
                chk("cyc_oe", {31'd0, coe}, {31'd0, cwr});
                bus_log.push_back({cwr, ca, cwr ? cd : rdv});
                if (!cwr && rd_q.size() > 0) void'(rd_q.pop_front());
            end
            if (!rd_n && rd_q.size() > 0) d_in = rd_q[0];
        end
    end

    // Command-level reference: what the 8253 should see and what comes back
    task automatic build_model(input cmd_t c, input logic [7:0] lo,
                               input logic [7:0] hi);
        bus_op_t o;
        exp_q.delete();
        exp_err  = (c.chan == 2'd3) || (c.rw == 2'd0)
                   || (!c.op && c.mode > 3'd5);
        exp_data = 16'h0000;
        if (!exp_err) begin
            o.wr   = 1;
            o.a    = 2'b11;
            o.data = c.op ? {c.chan, 6'd0} : {c.chan, c.rw, c.mode, c.bcd};
            exp_q.push_back(o);
            for (int b = 0; b < 2; b++) begin
                if (c.rw[b]) begin
                    o.wr   = !c.op;
                    o.a    = c.chan;
                    o.data = c.op ? (b == 1 ? hi : lo) : c.count[8*b +: 8];
                    exp_q.push_back(o);
                    if (c.op) exp_data[8*b +: 8] = (b == 1) ? hi : lo;
                end
            end
        end
    endtask

    task automatic drive_cmd(input cmd_t c);
        cmd_op    = c.op;
        cmd_chan  = c.chan;
        cmd_rw    = c.rw;
        cmd_mode  = c.mode;
        cmd_bcd   = c.bcd;
        cmd_count = c.count;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.op    = 1'($urandom_range(0, 1));
        c.chan  = ($urandom_range(0, 7) == 0) ? 2'd3
                                              : 2'($urandom_range(0, 2));
        c.rw    = ($urandom_range(0, 7) == 0) ? 2'd0
                                              : 2'($urandom_range(1, 3));
        c.mode  = 3'($urandom_range(0, 7));
        c.bcd   = 1'($urandom_range(0, 1));
        c.count = 16'($urandom());
        return c;
    endfunction

    task automatic run_cmd(input cmd_t c, input logic [7:0] lo,
                           input logic [7:0] hi, input bit noise);
        int lat;
        bit got;
        bit busy_ok;
        build_model(c, lo, hi);
        rd_q.delete();
        if (!exp_err && c.op) begin
            if (c.rw[0]) rd_q.push_back(lo);
            if (c.rw[1]) rd_q.push_back(hi);
        end
        bus_log.delete();
        @(negedge clk);
        drive_cmd(c);
        cmd_valid = 1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("accept", {31'd0, got}, 1);
        if (!got) begin
            cmd_valid = 0;
            return;
        end
        @(negedge clk);
        cmd_valid = 0;
        lat = 1; got = 0; busy_ok = 1;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) begin
                got = 1;
                break;
            end
            if (cmd_ready) busy_ok = 0;
            if (noise) begin
                drive_cmd(rand_cmd());
                cmd_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        cmd_valid = 0;
        last_err  = rsp_err;
        last_data = rsp_data;
        chk("rsp_seen", {31'd0, got}, 1);
        chk("busy_ready", {31'd0, busy_ok}, 1);
        chk("latency", lat, exp_err ? 1 : exp_q.size() * BUS_CYC + 1);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, exp_data});
        @(negedge clk);
        chk("rsp_pulse", {30'd0, rsp_valid, cmd_ready}, 1);
        chk("rsp_hold", {16'd0, rsp_data}, {16'd0, exp_data});
        chk("bus_len", bus_log.size(), exp_q.size());
        for (int i = 0; i < bus_log.size() && i < exp_q.size(); i++)
            chk("bus_op", {21'd0, bus_log[i]}, {21'd0, exp_q[i]});
    endtask

    task automatic addv(input logic op, input logic [1:0] chan,
                        input logic [1:0] rw, input logic [2:0] mode,
                        input logic bcd, input logic [15:0] count,
                        input logic [7:0] lo, input logic [7:0] hi,
                        input logic [7:0] ctrl, input int nwr, input int nrd,
                        input logic err, input logic [15:0] data);
        vec_t v;
        v.cmd      = {op, chan, rw, mode, bcd, count};
        v.lo       = lo;
        v.hi       = hi;
        v.exp_ctrl = ctrl;
        v.exp_nwr  = nwr;
        v.exp_nrd  = nrd;
        v.exp_err  = err;
        v.exp_data = data;
        vq.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c1;
        int   nwr, nrd, nfall, run, lat;
        bit   got, prev_wr, seen_rsp, seen_cs;
        int   acc_q[$], rsp_q[$], fall_q[$], run_q[$];

        //   op chan rw mode bcd count   lo     hi     ctrl   nwr nrd err data
        addv(0, 0, 3, 3, 0, 16'h1234, 8'h00, 8'h00, 8'h36, 3, 0, 0, 16'h0000);
        addv(0, 1, 1, 2, 0, 16'h0012, 8'h00, 8'h00, 8'h54, 2, 0, 0, 16'h0000);
        addv(1, 2, 3, 0, 0, 16'h0000, 8'h78, 8'h56, 8'h80, 1, 2, 0, 16'h5678);
        addv(0, 3, 3, 0, 0, 16'h1111, 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'h0000);
        addv(0, 0, 0, 0, 0, 16'h2222, 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'h0000);
        addv(0, 2, 3, 6, 0, 16'h3333, 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'h0000);
        addv(1, 1, 1, 7, 0, 16'h0000, 8'hAB, 8'h00, 8'h40, 1, 1, 0, 16'h00AB);
        addv(1, 0, 2, 0, 0, 16'h0000, 8'h00, 8'hCD, 8'h00, 1, 1, 0, 16'hCD00);
        addv(0, 2, 2, 5, 1, 16'hABCD, 8'h00, 8'h00, 8'hAB, 2, 0, 0, 16'h0000);
        addv(1, 3, 1, 0, 0, 16'h0000, 8'h11, 8'h22, 8'h00, 0, 0, 1, 16'h0000);
        addv(0, 1, 3, 0, 1, 16'hFFFF, 8'h00, 8'h00, 8'h71, 3, 0, 0, 16'h0000);

        rst_n = 0; cmd_valid = 0; d_in = 8'h00;
        drive_cmd('0);
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 0);
        chk("rst_data", {16'd0, rsp_data}, 0);
        chk("rst_strobes", {29'd0, cs_n, rd_n, wr_n}, 3'b111);
        chk("rst_addr", {30'd0, a1, a0}, 0);
        chk("rst_dout", {23'd0, d_out, d_oe}, 0);
        rst_n = 1;
        mon_en = 1;
        @(negedge clk);
        chk("rst_idle", {30'd0, cmd_ready, cs_n}, 2'b11);

        foreach (vq[i]) begin
            run_cmd(vq[i].cmd, vq[i].lo, vq[i].hi, 0);
            nwr = 0; nrd = 0;
            foreach (bus_log[j]) begin
                if (bus_log[j].wr) nwr++;
                else nrd++;
            end
            chk("tv_nwr", nwr, vq[i].exp_nwr);
            chk("tv_nrd", nrd, vq[i].exp_nrd);
            chk("tv_err", {31'd0, last_err}, {31'd0, vq[i].exp_err});
            chk("tv_data", {16'd0, last_data}, {16'd0, vq[i].exp_data});
            if (!vq[i].exp_err)
                chk("tv_ctrl",
                    bus_log.size() > 0 ? {24'd0, bus_log[0].data} : 32'h100,
                    {24'd0, vq[i].exp_ctrl});
        end

        // Reset during the strobe of the second write aborts silently
        c1 = {1'b0, 2'd0, 2'd3, 3'd3, 1'b0, 16'h1234};
        rd_q.delete();
        bus_log.delete();
        @(negedge clk);
        drive_cmd(c1);
        cmd_valid = 1;
        @(negedge clk);
        cmd_valid = 0;
        nfall = 0; prev_wr = 1;
        for (int i = 0; i < 40 && nfall < 2; i++) begin
            if (prev_wr && !wr_n) nfall++;
            prev_wr = wr_n;
            if (nfall < 2) @(negedge clk);
        end
        chk("abort_reach", nfall, 2);
        mon_en = 0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("abort_strobes", {29'd0, wr_n, cs_n, d_oe}, 3'b110);
        chk("abort_ready", {30'd0, cmd_ready, rsp_valid}, 2'b10);
        chk("abort_data", {16'd0, rsp_data}, 0);
        seen_rsp = 0; seen_cs = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp = 1;
            if (!cs_n) seen_cs = 1;
        end
        chk("abort_no_rsp", {30'd0, seen_rsp, seen_cs}, 0);
        bus_log.delete();
        mon_en = 1;

        // cmd_valid held high: second command only after the response
        @(negedge clk);
        drive_cmd(c1);
        cmd_valid = 1;
        prev_wr = 1; run = 0;
        for (int t = 0; t < 40; t++) begin
            if (cmd_valid && cmd_ready) acc_q.push_back(t);
            if (rsp_valid) rsp_q.push_back(t);
            if (prev_wr && !wr_n) fall_q.push_back(t);
            if (!wr_n) begin
                run++;
            end else if (run > 0) begin
                run_q.push_back(run);
                run = 0;
            end
            prev_wr = wr_n;
            @(negedge clk);
        end
        cmd_valid = 0;
        chk("hold_acc0", qget(acc_q, 0), 0);
        chk("hold_rsp", qget(rsp_q, 0), 3 * BUS_CYC + 1);
        chk("hold_acc1", qget(acc_q, 1), 3 * BUS_CYC + 2);
        chk("hold_nacc", acc_q.size(), 2);
        chk("hold_space1", qget(fall_q, 1) - qget(fall_q, 0), BUS_CYC);
        chk("hold_space2", qget(fall_q, 2) - qget(fall_q, 1), BUS_CYC);
        chk("hold_wr_len0", qget(run_q, 0), ST);
        chk("hold_wr_len2", qget(run_q, 2), ST);
        got = 0; lat = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (rsp_valid) got = 1;
            else @(negedge clk);
        end
        chk("hold_rsp2", {31'd0, got}, 1);
        @(negedge clk);
        bus_log.delete();

        for (int i = 0; i < 40; i++)
            run_cmd(rand_cmd(), 8'($urandom()), 8'($urandom()),
                    bit'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
